// File: rtl/rice_core_divider.sv
// rice_core_divider: iterative radix-2 divider for RV32M DIV/DIVU/REM/REMU.
// One quotient bit per cycle via restoring division on absolute values,
// with sign fix-up applied when the result is registered.
// Optional build macro: RICE_CORE_DIVIDER_ZERO_SKIP_EN -- a zero divisor
// bypasses the iterations and produces the divide-by-zero result directly.
module rice_core_divider #(
  parameter int unsigned XLEN = 32
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [1:0]      i_command,
  input  logic [XLEN-1:0] i_rs1_value,
  input  logic [XLEN-1:0] i_rs2_value,
  input  logic            i_flush,
  output logic            o_valid,
  input  logic            i_ready,
  output logic [XLEN-1:0] o_result,
  output logic            o_busy
);

  localparam int unsigned CNT_W = (XLEN > 1) ? $clog2(XLEN) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(XLEN - 1);

  localparam logic [1:0] CMD_DIV = 2'b00;
  localparam logic [1:0] CMD_REM = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [1:0]        cmd_q;
  logic              sign_a_q, sign_b_q;
  logic [XLEN-1:0]   quot_q;      // holds |dividend| initially, shifts out MSB-first
  logic [XLEN-1:0]   rem_q;
  logic [XLEN-1:0]   divisor_q;
  logic [CNT_W-1:0]  count_q;
  logic [XLEN-1:0]   result_q;

  logic              accept;
  logic              is_signed_in;
  logic [XLEN-1:0]   abs_a, abs_b;
  logic              zero_skip;
  logic [XLEN:0]     shifted, diff;
  logic [XLEN-1:0]   quot_next, rem_next;
  logic [XLEN-1:0]   quot_fix, rem_fix, result_d;
  logic              negate_q;

  assign accept       = (state_q == S_IDLE) && i_valid && !i_flush;
  assign is_signed_in = !i_command[0];
  assign abs_a = (is_signed_in && i_rs1_value[XLEN-1]) ? (~i_rs1_value + 1'b1) : i_rs1_value;
  assign abs_b = (is_signed_in && i_rs2_value[XLEN-1]) ? (~i_rs2_value + 1'b1) : i_rs2_value;

`ifdef RICE_CORE_DIVIDER_ZERO_SKIP_EN
  assign zero_skip = (i_rs2_value == '0);
`else
  assign zero_skip = 1'b0;
`endif

  // One restoring step: shift in next dividend bit, trial-subtract, keep if non-negative.
  always_comb begin
    shifted   = {rem_q, quot_q[XLEN-1]};
    diff      = shifted - {1'b0, divisor_q};
    rem_next  = diff[XLEN] ? shifted[XLEN-1:0] : diff[XLEN-1:0];
    quot_next = {quot_q[XLEN-2:0], ~diff[XLEN]};
  end

  // Sign fix-up of the final step; divide-by-zero leaves the all-ones quotient alone.
  always_comb begin
    negate_q = (cmd_q == CMD_DIV) && (sign_a_q ^ sign_b_q) && (divisor_q != '0);
    quot_fix = negate_q ? (~quot_next + 1'b1) : quot_next;
    rem_fix  = ((cmd_q == CMD_REM) && sign_a_q) ? (~rem_next + 1'b1) : rem_next;
    result_d = cmd_q[1] ? rem_fix : quot_fix;
  end

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic; flush overrides every other transition.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (i_valid) state_d = zero_skip ? S_DONE : S_BUSY;
      S_BUSY: if (count_q == LAST_CNT) state_d = S_DONE;
      S_DONE: if (i_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (i_flush) state_d = S_IDLE;
  end

  // Output decode from registered state only.
  always_comb begin
    o_ready  = (state_q == S_IDLE);
    o_valid  = (state_q == S_DONE);
    o_busy   = (state_q != S_IDLE);
    o_result = result_q;
  end

  // Datapath: operand capture, iteration, and result registration.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cmd_q     <= '0;
      sign_a_q  <= 1'b0;
      sign_b_q  <= 1'b0;
      quot_q    <= '0;
      rem_q     <= '0;
      divisor_q <= '0;
      count_q   <= '0;
      result_q  <= '0;
    end else if (accept) begin
      cmd_q     <= i_command;
      sign_a_q  <= is_signed_in && i_rs1_value[XLEN-1];
      sign_b_q  <= is_signed_in && i_rs2_value[XLEN-1];
      quot_q    <= abs_a;
      rem_q     <= '0;
      divisor_q <= abs_b;
      count_q   <= '0;
      if (zero_skip) result_q <= i_command[1] ? i_rs1_value : '1;
    end else if ((state_q == S_BUSY) && !i_flush) begin
      quot_q  <= quot_next;
      rem_q   <= rem_next;
      count_q <= count_q + 1'b1;
      if (count_q == LAST_CNT) result_q <= result_d;
    end
  end

endmodule
